// File: rtl/f2s_pulse_sync_fb.sv
// f2s_pulse_sync_fb: moves a single-cycle request pulse from the every-clk domain
// into the slow_ce-gated domain with a toggle req/ack feedback handshake.
// busy tells the producer when another pulse may be issued.
// Optional build macro: F2S_DROP_CNT_EN adds a saturating count of pulses ignored while busy.
module f2s_pulse_sync_fb #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slow_ce,
  input  logic             in_pulse,
  output logic             busy,
  output logic             out_pulse,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int unsigned LAST = SYNC_STAGES - 1;

  logic                   r_req_tgl;
  logic [SYNC_STAGES-1:0] r_req_s;
  logic                   r_req_last;
  logic [SYNC_STAGES-1:0] r_ack_f;

  logic w_busy;
  logic w_accept;

  // A transfer is in flight until the acknowledge toggle catches up with the request toggle.
  assign w_busy   = r_req_tgl ^ r_ack_f[LAST];
  assign w_accept = in_pulse & ~w_busy;

  // Fast side: each accepted pulse flips the request toggle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_tgl <= 1'b0;
    end else if (w_accept) begin
      r_req_tgl <= ~r_req_tgl;
    end
  end

  // Slow side: synchronize the request toggle and remember its previous value, on slow_ce only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_s    <= '0;
      r_req_last <= 1'b0;
    end else if (slow_ce) begin
      r_req_s    <= {r_req_s[SYNC_STAGES-2:0], r_req_tgl};
      r_req_last <= r_req_s[LAST];
    end
  end

  // Feedback: bring the slow-side toggle back to the fast side every clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack_f <= '0;
    end else begin
      r_ack_f <= {r_ack_f[SYNC_STAGES-2:0], r_req_s[LAST]};
    end
  end

  assign busy      = w_busy;
  // Edge of the synchronized toggle, held for one full slow_ce interval.
  assign out_pulse = r_req_s[LAST] ^ r_req_last;

`ifdef F2S_DROP_CNT_EN
  logic [CNT_W-1:0] r_drop_cnt;

  // Count pulses that arrive while a transfer is in flight, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (in_pulse && w_busy && (r_drop_cnt != {CNT_W{1'b1}})) begin
      r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_f2s_pulse_sync_fb.sv
// tb_f2s_pulse_sync_fb: directed bench for the fast-to-slow pulse synchronizer.
// Honours F2S_DROP_CNT_EN for the expected drop count.
module tb_f2s_pulse_sync_fb;

  logic       clk;
  logic       rst;
  logic       slow_ce;
  logic       in_pulse;
  logic       busy;
  logic       out_pulse;
  logic [7:0] drop_cnt;

  logic stall = 1'b0;
  logic ph    = 1'b0;

  int total = 0;
  int bad   = 0;

`ifdef F2S_DROP_CNT_EN
  localparam int EXP_DROP = 3;
`else
  localparam int EXP_DROP = 0;
`endif

  f2s_pulse_sync_fb #(.SYNC_STAGES(2), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .slow_ce  (slow_ce),
    .in_pulse (in_pulse),
    .busy     (busy),
    .out_pulse(out_pulse),
    .drop_cnt (drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // slow_ce high every 2nd clk unless stalled
  initial begin
    slow_ce = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ph      = ~ph;
      slow_ce = ph & ~stall;
    end
  end

  // Issue one pulse; returns the slow_ce value seen at the accepting edge. Ends 1ns after it.
  task automatic pulse_once(output logic ce_at_a);
    @(posedge clk);
    #1 in_pulse = 1'b1;
    @(negedge clk);
    ce_at_a = slow_ce;
    @(posedge clk);
    #1 in_pulse = 1'b0;
  endtask

  // Sample n negedges; sample index 0 is the first negedge from now.
  task automatic run_window(input int n, output int first_rise, output int hi, output int rises,
                            output logic busy_first, output int busy_fall, output int busy_hi,
                            output logic busy_last);
    logic prev;
    prev       = 1'b0;
    first_rise = -1;
    hi         = 0;
    rises      = 0;
    busy_first = 1'b0;
    busy_fall  = -1;
    busy_hi    = 0;
    busy_last  = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) busy_first = busy;
      if (out_pulse) hi++;
      if (out_pulse && !prev) begin
        rises++;
        if (first_rise < 0) first_rise = k;
      end
      if (!busy && busy_fall < 0) busy_fall = k;
      if (busy) busy_hi++;
      prev      = out_pulse;
      busy_last = busy;
    end
  endtask

  task automatic test_reset();
    int fr, hi, ri, bf, bh;
    logic b0, bl;
    rst      = 1'b1;
    in_pulse = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({busy, out_pulse, drop_cnt} !== 10'd0) begin
        bad++;
        $display("FAIL reset_outputs cyc=%0d got busy=%b out=%b drop=%0d want 0/0/0",
                 i, busy, out_pulse, drop_cnt);
      end
      @(posedge clk);
      #1 in_pulse = ~in_pulse;
    end
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_pulse = 1'b0;
    run_window(10, fr, hi, ri, b0, bf, bh, bl);
    total++;
    if (hi !== 0) begin
      bad++;
      $display("FAIL reset_no_out got out_hi=%0d want 0", hi);
    end
    total++;
    if (bh !== 0) begin
      bad++;
      $display("FAIL reset_no_busy got busy_hi=%0d want 0", bh);
    end
  endtask

  task automatic test_single();
    int fr, hi, ri, bf, bh, exp_rise;
    logic b0, bl, ce;
    pulse_once(ce);
    exp_rise = ce ? 4 : 3;
    run_window(10, fr, hi, ri, b0, bf, bh, bl);
    total++;
    if (b0 !== 1'b1) begin
      bad++;
      $display("FAIL single_busy_rise got %b want 1", b0);
    end
    total++;
    if (fr !== exp_rise) begin
      bad++;
      $display("FAIL single_latency got %0d want %0d", fr, exp_rise);
    end
    total++;
    if (hi !== 2 || ri !== 1) begin
      bad++;
      $display("FAIL single_out_shape got hi=%0d rises=%0d want 2/1", hi, ri);
    end
    total++;
    if (bf !== exp_rise + 2) begin
      bad++;
      $display("FAIL single_busy_fall got %0d want %0d", bf, exp_rise + 2);
    end
  endtask

  task automatic test_back_to_back();
    int fr, hi, ri, bf, bh, sum_r, exp_rise;
    logic b0, bl, ce;
    pulse_once(ce);
    run_window(8, fr, hi, ri, b0, bf, bh, bl);
    sum_r = ri;
    total++;
    if (hi !== 2 || ri !== 1 || bl !== 1'b0) begin
      bad++;
      $display("FAIL b2b_first got hi=%0d rises=%0d busy=%b want 2/1/0", hi, ri, bl);
    end
    pulse_once(ce);
    exp_rise = ce ? 4 : 3;
    run_window(8, fr, hi, ri, b0, bf, bh, bl);
    sum_r += ri;
    total++;
    if (fr !== exp_rise || hi !== 2 || bl !== 1'b0) begin
      bad++;
      $display("FAIL b2b_second got rise=%0d hi=%0d busy=%b want %0d/2/0", fr, hi, bl, exp_rise);
    end
    total++;
    if (sum_r !== 2) begin
      bad++;
      $display("FAIL b2b_total got %0d want 2", sum_r);
    end
  endtask

  task automatic test_busy_drop();
    int fr, hi, ri, bf, bh;
    logic b0, bl, ce;
    pulse_once(ce);
    in_pulse = 1'b1;
    repeat (3) @(posedge clk);
    #1 in_pulse = 1'b0;
    run_window(10, fr, hi, ri, b0, bf, bh, bl);
    total++;
    if (ri !== 1 || hi !== 2 || bl !== 1'b0) begin
      bad++;
      $display("FAIL drop_single_out got rises=%0d hi=%0d busy=%b want 1/2/0", ri, hi, bl);
    end
    total++;
    if (drop_cnt !== 8'(EXP_DROP)) begin
      bad++;
      $display("FAIL drop_count got %0d want %0d", drop_cnt, EXP_DROP);
    end
  endtask

  task automatic test_stall();
    int fr, hi, ri, bf, bh;
    logic b0, bl, ce;
    @(negedge clk);
    stall = 1'b1;
    pulse_once(ce);
    run_window(20, fr, hi, ri, b0, bf, bh, bl);
    total++;
    if (bh !== 20 || hi !== 0) begin
      bad++;
      $display("FAIL stall_hold got busy_hi=%0d out_hi=%0d want 20/0", bh, hi);
    end
    @(negedge clk);
    stall = 1'b0;
    run_window(12, fr, hi, ri, b0, bf, bh, bl);
    total++;
    if (ri !== 1 || hi !== 2) begin
      bad++;
      $display("FAIL stall_resume_out got rises=%0d hi=%0d want 1/2", ri, hi);
    end
    total++;
    if (bl !== 1'b0) begin
      bad++;
      $display("FAIL stall_resume_busy got %b want 0", bl);
    end
  endtask

  task automatic test_reset_mid();
    int fr, hi, ri, bf, bh, exp_rise;
    logic b0, bl, ce;
    pulse_once(ce);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || out_pulse !== 1'b0) begin
      bad++;
      $display("FAIL midrst_clear got busy=%b out=%b want 0/0", busy, out_pulse);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    run_window(12, fr, hi, ri, b0, bf, bh, bl);
    total++;
    if (hi !== 0 || bh !== 0) begin
      bad++;
      $display("FAIL midrst_quiet got out_hi=%0d busy_hi=%0d want 0/0", hi, bh);
    end
    total++;
    if (drop_cnt !== 8'd0) begin
      bad++;
      $display("FAIL midrst_drop got %0d want 0", drop_cnt);
    end
    pulse_once(ce);
    exp_rise = ce ? 4 : 3;
    run_window(10, fr, hi, ri, b0, bf, bh, bl);
    total++;
    if (fr !== exp_rise || hi !== 2 || bf !== exp_rise + 2) begin
      bad++;
      $display("FAIL midrst_next got rise=%0d hi=%0d fall=%0d want %0d/2/%0d",
               fr, hi, bf, exp_rise, exp_rise + 2);
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_pulse = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_drop();
    test_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
